pwm_bank: RTL and testbench

//  Parametrised multi-channel PWM generator, next generation of the servo PWM block.

---
 rtl/pwm_bank_if.sv | 13 +
 rtl/pwm_bank.sv | 186 ++++++++++++++++++
 tb/tb_pwm_bank.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// Register bus between the i2cSlave front end and pwm_bank.
// Bus semantics: a write happens at every Clk edge where WEn is high, taking
// WData into the register at Addr; there is no ready/back-pressure. RData is
// combinational from Addr and valid whenever Addr is stable.
interface pwm_bank_if;
    logic [7:0] Addr;
    logic [7:0] WData;
    logic       WEn;
    logic [7:0] RData;

    modport master (output Addr, output WData, output WEn, input RData);
    modport slave  (input Addr, input WData, input WEn, output RData);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with a shared prescaler and period
// counter. Compare and period values are written to shadow registers and
// copied to the active set atomically at period wrap, on FORCE_LOAD, or
// continuously while disabled.
// Optional feature: define PWM_POLARITY_EN to add the per-channel output
// polarity register at 0x26/0x27.
module pwm_bank #(
    parameter int NUM_CH       = 8,
    parameter int CNT_W        = 16,
    parameter int PRESCALE_RST = 49,
    parameter int PERIOD_RST   = 19999
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pwm_bank_if.slave         bus,
    output logic              Period_Start,
    output logic [NUM_CH-1:0] Pwm_Out
);

    // Replace one byte of a counter-width register; bits above CNT_W drop out.
    function automatic logic [CNT_W-1:0] wr_byte(input logic [CNT_W-1:0] cur,
                                                 input logic hi,
                                                 input logic [7:0] b);
        logic [15:0] w;
        w = 16'(cur);
        if (hi) w[15:8] = b;
        else    w[7:0]  = b;
        return w[CNT_W-1:0];
    endfunction

    function automatic logic [7:0] rd_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    logic [NUM_CH-1:0][CNT_W-1:0] cmp_sh_q, cmp_sh_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cmp_act_q, cmp_act_d;
    logic [CNT_W-1:0]             per_sh_q, per_sh_d;
    logic [CNT_W-1:0]             per_act_q, per_act_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [15:0]                  presc_q, presc_d;
    logic [15:0]                  pre_q, pre_d;
    logic                         en_q, en_d;
    logic                         ps_q, ps_d;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;
`ifdef PWM_POLARITY_EN
    logic [NUM_CH-1:0]            pol_q, pol_d;
`endif

    logic              force_load;
    logic              tick;
    logic              wrap;
    logic              reload;
    logic              load_pend;
    logic [NUM_CH-1:0] pwm_raw;

    assign force_load = bus.WEn && (bus.Addr == 8'h24) && bus.WData[1];
    assign tick       = en_q && (pre_q == presc_q);
    assign wrap       = tick && (cnt_q >= per_act_q);
    assign reload     = wrap || force_load || !en_q;
    assign load_pend  = (cmp_sh_q != cmp_act_q) || (per_sh_q != per_act_q);

    // Register-file writes: shadow compares/period, prescaler, enable, polarity.
    always_comb begin
        cmp_sh_d = cmp_sh_q;
        per_sh_d = per_sh_q;
        presc_d  = presc_q;
        en_d     = en_q;
`ifdef PWM_POLARITY_EN
        pol_d    = pol_q;
`endif
        if (bus.WEn) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.Addr[7:1] == 7'(n))
                    cmp_sh_d[n] = wr_byte(cmp_sh_q[n], bus.Addr[0], bus.WData);
            end
            case (bus.Addr)
                8'h20, 8'h21: per_sh_d = wr_byte(per_sh_q, bus.Addr[0], bus.WData);
                8'h22:        presc_d[7:0]  = bus.WData;
                8'h23:        presc_d[15:8] = bus.WData;
                8'h24:        en_d = bus.WData[0];
`ifdef PWM_POLARITY_EN
                8'h26, 8'h27: begin
                    logic [15:0] pw;
                    pw = 16'(pol_q);
                    if (bus.Addr[0]) pw[15:8] = bus.WData;
                    else             pw[7:0]  = bus.WData;
                    pol_d = pw[NUM_CH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    // Prescaler, period counter, atomic shadow->active reload and output compare.
    always_comb begin
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        cmp_act_d = cmp_act_q;
        per_act_d = per_act_q;
        ps_d      = 1'b0;
        pwm_raw   = '0;

        // A prescaler above a freshly lowered PRESCALE wraps without a tick.
        if (!en_q || force_load)    pre_d = '0;
        else if (pre_q >= presc_q)  pre_d = '0;
        else                        pre_d = pre_q + 16'd1;

        if (!en_q || force_load)    cnt_d = '0;
        else if (wrap)              cnt_d = '0;
        else if (tick)              cnt_d = cnt_q + CNT_W'(1);

        // Reload reads the pre-write shadow, so a write landing on the wrap
        // edge only takes effect one frame later.
        if (reload) begin
            cmp_act_d = cmp_sh_q;
            per_act_d = per_sh_q;
        end

        ps_d = wrap && !force_load;

        for (int n = 0; n < NUM_CH; n++)
            pwm_raw[n] = en_q && (cnt_q < cmp_act_q[n]);
`ifdef PWM_POLARITY_EN
        pwm_d = pwm_raw ^ pol_q;
`else
        pwm_d = pwm_raw;
`endif
    end

    // State registers, all returning to reset values asynchronously.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmp_sh_q  <= '0;
            cmp_act_q <= '0;
            per_sh_q  <= CNT_W'(PERIOD_RST);
            per_act_q <= CNT_W'(PERIOD_RST);
            presc_q   <= 16'(PRESCALE_RST);
            pre_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            ps_q      <= 1'b0;
            pwm_q     <= '0;
`ifdef PWM_POLARITY_EN
            pol_q     <= '0;
`endif
        end else begin
            cmp_sh_q  <= cmp_sh_d;
            cmp_act_q <= cmp_act_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            presc_q   <= presc_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            ps_q      <= ps_d;
            pwm_q     <= pwm_d;
`ifdef PWM_POLARITY_EN
            pol_q     <= pol_d;
`endif
        end
    end

    // Combinational read-back; unmapped addresses and unused bits read 0.
    always_comb begin
        bus.RData = 8'h00;
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.Addr[7:1] == 7'(n))
                bus.RData = rd_byte(16'(cmp_sh_q[n]), bus.Addr[0]);
        end
        case (bus.Addr)
            8'h20, 8'h21: bus.RData = rd_byte(16'(per_sh_q), bus.Addr[0]);
            8'h22, 8'h23: bus.RData = rd_byte(presc_q, bus.Addr[0]);
            8'h24:        bus.RData = {7'b0, en_q};
            8'h25:        bus.RData = {7'b0, load_pend};
`ifdef PWM_POLARITY_EN
            8'h26, 8'h27: bus.RData = rd_byte(16'(pol_q), bus.Addr[0]);
`endif
            default: ;
        endcase
    end

    assign Period_Start = ps_q;
    assign Pwm_Out      = pwm_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: PRESCALE=1 so one tick is 2 Clk. Each completed frame
// (Period_Start to Period_Start) is measured as {length, ch0 high, ch1 high}
// in Clk cycles and compared against expected frames queued by the driver.
module tb_pwm_bank;

    localparam int NUM_CH = 8;

    logic              Clk;
    logic              Rst_n;
    logic              Period_Start;
    logic [NUM_CH-1:0] Pwm_Out;

    pwm_bank_if bus();

    pwm_bank #(
        .NUM_CH(NUM_CH), .CNT_W(16), .PRESCALE_RST(49), .PERIOD_RST(19999)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus),
        .Period_Start(Period_Start),
        .Pwm_Out(Pwm_Out)
    );

    // Clock and watchdog
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected frames {len, hi0, hi1}
    logic [47:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic        have_start = 1'b0;
    int          f_len, f_hi0, f_hi1;

    always @(negedge Clk) begin
        if (!Rst_n || !mon_en) begin
            have_start = 1'b0;
        end else begin
            if (Period_Start) begin
                if (have_start && exp_q.size() > 0) begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check("frame_len", 32'(f_len), 32'(e[47:32]));
                    check("frame_hi0", 32'(f_hi0), 32'(e[31:16]));
                    check("frame_hi1", 32'(f_hi1), 32'(e[15:0]));
                end
                have_start = 1'b1;
                f_len = 0; f_hi0 = 0; f_hi1 = 0;
            end
            f_len++;
            if (Pwm_Out[0]) f_hi0++;
            if (Pwm_Out[1]) f_hi1++;
        end
    end

    // Driver tasks
    // Call just after a posedge: write is captured at the next posedge.
    task automatic wr_now(input logic [7:0] a, input logic [7:0] d);
        bus.Addr = a; bus.WData = d; bus.WEn = 1'b1;
        @(posedge Clk); #1;
        bus.WEn = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge Clk); #1;
        wr_now(a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.Addr = a;
        #1;
        check(tag, 32'(bus.RData), 32'(exp));
    endtask

    task automatic wait_ps(input string tag);
        int g;
        g = 0;
        @(negedge Clk);
        while (!Period_Start && g < 300) begin
            @(negedge Clk);
            g++;
        end
        check(tag, 32'(Period_Start), 32'd1);
    endtask

    task automatic push_frame(input int len, input int h0, input int h1);
        exp_q.push_back({16'(len), 16'(h0), 16'(h1)});
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 600) begin
            @(negedge Clk);
            g++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    initial begin
        int k;
        bus.Addr = 8'h00; bus.WData = 8'h00; bus.WEn = 1'b0;
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state
        check("rst_pwm", 32'(Pwm_Out), 32'd0);
        check("rst_ps", 32'(Period_Start), 32'd0);
        rd_chk("rst_per_lo", 8'h20, 8'h1F);
        rd_chk("rst_per_hi", 8'h21, 8'h4E);
        rd_chk("rst_psc_lo", 8'h22, 8'h31);
        rd_chk("rst_psc_hi", 8'h23, 8'h00);
        rd_chk("rst_ctrl", 8'h24, 8'h00);
        rd_chk("rst_cmp0", 8'h00, 8'h00);
        Rst_n = 1'b1;

        // Basic configuration: PRESCALE=1, PERIOD=9, CMP0=3, CMP1=10
        wr(8'h22, 8'h01); wr(8'h23, 8'h00);
        wr(8'h20, 8'h09); wr(8'h21, 8'h00);
        wr(8'h00, 8'h03); wr(8'h02, 8'h0A);
        wr(8'h10, 8'hAA); wr(8'h30, 8'h55);
        @(negedge Clk);
        rd_chk("cmp0_rb", 8'h00, 8'h03);
        rd_chk("cmp1_rb", 8'h02, 8'h0A);
        rd_chk("cmp8_absent", 8'h10, 8'h00);
        rd_chk("unmapped", 8'h30, 8'h00);
        rd_chk("stat_en0", 8'h25, 8'h00);
        check("en0_pwm", 32'(Pwm_Out), 32'd0);
        wr(8'h24, 8'h01);
        mon_en = 1'b1;
        repeat (3) push_frame(20, 6, 20);
        drain("sb_basic");

        // CMP0=0: channel 0 never high, channel 1 never low
        wr(8'h00, 8'h00);
        mon_en = 1'b1;
        repeat (3) push_frame(20, 0, 20);
        drain("sb_cmp0_zero");

        // Mid-frame write at cnt=4: old duty holds until wrap
        wait_ps("ps_mid");
        repeat (8) @(posedge Clk);
        #1; wr_now(8'h00, 8'h05);
        #1; rd_chk("stat_pend", 8'h25, 8'h01);
        repeat (2) @(negedge Clk);
        check("mid_old_duty", 32'(Pwm_Out[0]), 32'd0);
        wait_ps("ps_mid2");
        #1; rd_chk("stat_clr", 8'h25, 8'h00);
        mon_en = 1'b1;
        push_frame(20, 10, 20);
        drain("sb_mid");

        // Write coinciding with wrap: old shadow loads, new value a frame later
        wait_ps("ps_coinc");
        repeat (19) @(posedge Clk);
        #1; wr_now(8'h00, 8'h02);
        rd_chk("stat_coinc", 8'h25, 8'h01);
        mon_en = 1'b1;
        push_frame(20, 10, 20);
        push_frame(20, 4, 20);
        drain("sb_coinc");

        // FORCE_LOAD with PERIOD=4 at cnt=7
        wait_ps("ps_force");
        @(posedge Clk);
        #1; wr_now(8'h20, 8'h04);
        #1; rd_chk("stat_per_pend", 8'h25, 8'h01);
        repeat (12) @(posedge Clk);
        #1; wr_now(8'h24, 8'h03);
        #1; rd_chk("stat_forced", 8'h25, 8'h00);
        rd_chk("ctrl_fl_clr", 8'h24, 8'h01);
        k = 0;
        @(negedge Clk);
        while (!Period_Start && k < 100) begin
            k++;
            @(negedge Clk);
        end
        check("force_restart", 32'(k), 32'd10);
        mon_en = 1'b1;
        repeat (2) push_frame(10, 4, 10);
        drain("sb_force");

        // PERIOD=0: counter stays 0, wrap every tick
        wr(8'h20, 8'h00);
        wait_ps("ps_p0a");
        wait_ps("ps_p0b");
        mon_en = 1'b1;
        repeat (3) push_frame(2, 2, 2);
        drain("sb_per0");

        // Mid-operation reset with outputs high
        @(negedge Clk);
        check("pre_rst_pwm1", 32'(Pwm_Out[1]), 32'd1);
        #3 Rst_n = 1'b0;
        #1;
        check("midrst_pwm", 32'(Pwm_Out), 32'd0);
        check("midrst_ps", 32'(Period_Start), 32'd0);
        rd_chk("midrst_per_lo", 8'h20, 8'h1F);
        rd_chk("midrst_cmp0", 8'h00, 8'h00);
        rd_chk("midrst_ctrl", 8'h24, 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Polarity register
        wr(8'h26, 8'h01);
        repeat (2) @(negedge Clk);
`ifdef PWM_POLARITY_EN
        rd_chk("pol_rb", 8'h26, 8'h01);
        check("pol_inactive", 32'(Pwm_Out), 32'h01);
`else
        rd_chk("pol_absent", 8'h26, 8'h00);
        check("pol_none", 32'(Pwm_Out), 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
